// File: rtl/messbauer_pkg.sv
// ---------------------------------------------------------------------------
// messbauer_pkg
// Shared definitions for the Messbauer start/channel link: channel-strobe
// timing mode constants, the receiver FSM state encoding and the default
// number of velocity channels (shared with the generator side).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package messbauer_pkg;

    // Channel strobes independent of start: first channel after start is ch 0
    localparam int CHANNEL_TYPE_ASYNC = 0;
    // Start and channel synchronous: a channel coincident with start is ch 0
    localparam int CHANNEL_TYPE_SYNC  = 1;

    localparam int DEFAULT_NCHANNELS  = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } rx_state_t;

    // True when the channel strobe coincident with start counts as channel 0
    function automatic bit isSyncMode(input int channelType);
        return channelType == CHANNEL_TYPE_SYNC;
    endfunction

endpackage

// File: rtl/messbauer_channel_receiver_if.sv
// ---------------------------------------------------------------------------
// messbauer_channel_receiver_if
// Bundles the start/channel strobe inputs, the control inputs and the
// reconstructed-channel outputs of the Messbauer channel receiver.
//   master : drives start, channel, enable, err_clear; observes results
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface messbauer_channel_receiver_if #(
    parameter int CHANNEL_WIDTH = 9,
    parameter int CYCLE_WIDTH   = 16
);

    logic                     start;
    logic                     channel;
    logic                     enable;
    logic                     err_clear;
    logic                     channel_valid;
    logic [CHANNEL_WIDTH-1:0] channel_index;
    logic                     cycle_done;
    logic [CYCLE_WIDTH-1:0]   cycle_count;
    logic                     err_short;
    logic                     err_overrun;

    modport master (
        output start, channel, enable, err_clear,
        input  channel_valid, channel_index, cycle_done, cycle_count,
               err_short, err_overrun
    );

    modport slave (
        input  start, channel, enable, err_clear,
        output channel_valid, channel_index, cycle_done, cycle_count,
               err_short, err_overrun
    );

endinterface

// File: rtl/messbauer_strobe_sync.sv
// ---------------------------------------------------------------------------
// messbauer_strobe_sync
// Brings one asynchronous strobe into the aclk domain through a two-flop
// synchronizer, then turns its rising edge into a single-cycle pulse.
//   aclk     : system clock
//   areset   : asynchronous active-high reset
//   strobe_i : asynchronous strobe level (held high for >= 2 aclk)
//   pulse_o  : one-cycle pulse, 3 aclk after the strobe is first sampled
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module messbauer_strobe_sync (
    input  logic aclk,
    input  logic areset,
    input  logic strobe_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic delay_q;
    logic pulse_q;
    logic pulse_d;

    // Rising edge of the synchronized level: high now, low one cycle ago.
    // A level held for many cycles therefore yields exactly one pulse.
    always_comb begin
        pulse_d = sync_q & ~delay_q;
    end

    // Synchronizer chain plus delay stage; the edge pulse is registered so
    // downstream logic sees a clean single-cycle strobe.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            delay_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= strobe_i;
            sync_q  <= meta_q;
            delay_q <= sync_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/messbauer_channel_receiver.sv
// ---------------------------------------------------------------------------
// messbauer_channel_receiver
// Acquisition-side end of the Messbauer start/channel link. Reconstructs the
// velocity channel index from start/channel strobes, pulses channel_valid
// once per accepted channel, pulses cycle_done when a start closes a cycle
// of exactly NCHANNELS channels, and keeps sticky framing-error flags.
//   aclk, areset : clock and asynchronous active-high reset
//   bus (slave)  : start, channel, enable, err_clear in;
//                  channel_valid, channel_index, cycle_done, cycle_count,
//                  err_short, err_overrun out
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module messbauer_channel_receiver
    import messbauer_pkg::*;
#(
    parameter int CHANNEL_TYPE  = CHANNEL_TYPE_ASYNC,
    parameter int NCHANNELS     = DEFAULT_NCHANNELS,
    parameter int CHANNEL_WIDTH = 9,
    parameter int CYCLE_WIDTH   = 16
) (
    input logic                          aclk,
    input logic                          areset,
    messbauer_channel_receiver_if.slave  bus
);

    localparam bit                   SYNC_MODE = isSyncMode(CHANNEL_TYPE);
    localparam logic [CHANNEL_WIDTH:0] NCH     = (CHANNEL_WIDTH+1)'(NCHANNELS);
    localparam logic [CHANNEL_WIDTH:0] CNT_ONE = (CHANNEL_WIDTH+1)'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = CYCLE_WIDTH'(1);

    logic startStb;
    logic chanStb;

    rx_state_t                state_q,        state_d;
    logic [CHANNEL_WIDTH:0]   chanCnt_q,      chanCnt_d;
    logic                     channelValid_q, channelValid_d;
    logic [CHANNEL_WIDTH-1:0] channelIndex_q, channelIndex_d;
    logic                     cycleDone_q,    cycleDone_d;
    logic [CYCLE_WIDTH-1:0]   cycleCount_q,   cycleCount_d;
    logic                     errShort_q,     errShort_d;
    logic                     errOverrun_q,   errOverrun_d;

    messbauer_strobe_sync uStartSync (
        .aclk     (aclk),
        .areset   (areset),
        .strobe_i (bus.start),
        .pulse_o  (startStb)
    );

    messbauer_strobe_sync uChanSync (
        .aclk     (aclk),
        .areset   (areset),
        .strobe_i (bus.channel),
        .pulse_o  (chanStb)
    );

    // Next-state and output decode. A start in RUN closes the current cycle
    // (complete or short) and re-arms; in synchronous mode a channel strobe
    // coincident with that start is ch 0 of the new cycle, otherwise it is
    // dropped. Error clears are applied first so a same-cycle set wins.
    always_comb begin
        state_d        = state_q;
        chanCnt_d      = chanCnt_q;
        channelValid_d = 1'b0;
        channelIndex_d = channelIndex_q;
        cycleDone_d    = 1'b0;
        cycleCount_d   = cycleCount_q;
        errShort_d     = errShort_q & ~bus.err_clear;
        errOverrun_d   = errOverrun_q & ~bus.err_clear;

        if (!bus.enable) begin
            state_d   = ST_IDLE;
            chanCnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startStb) begin
                        state_d   = ST_SYNC;
                        chanCnt_d = '0;
                        if (SYNC_MODE && chanStb) begin
                            state_d        = ST_RUN;
                            channelValid_d = 1'b1;
                            channelIndex_d = '0;
                            chanCnt_d      = CNT_ONE;
                        end
                    end
                end

                ST_SYNC: begin
                    if (startStb) begin
                        chanCnt_d = '0;
                        if (SYNC_MODE && chanStb) begin
                            state_d        = ST_RUN;
                            channelValid_d = 1'b1;
                            channelIndex_d = '0;
                            chanCnt_d      = CNT_ONE;
                        end
                    end else if (chanStb) begin
                        state_d        = ST_RUN;
                        channelValid_d = 1'b1;
                        channelIndex_d = '0;
                        chanCnt_d      = CNT_ONE;
                    end
                end

                ST_RUN: begin
                    if (startStb) begin
                        if (chanCnt_q == NCH) begin
                            cycleDone_d  = 1'b1;
                            cycleCount_d = cycleCount_q + CYC_ONE;
                        end else begin
                            errShort_d = 1'b1;
                        end
                        state_d   = ST_SYNC;
                        chanCnt_d = '0;
                        if (SYNC_MODE && chanStb) begin
                            state_d        = ST_RUN;
                            channelValid_d = 1'b1;
                            channelIndex_d = '0;
                            chanCnt_d      = CNT_ONE;
                        end
                    end else if (chanStb) begin
                        if (chanCnt_q < NCH) begin
                            channelValid_d = 1'b1;
                            channelIndex_d = chanCnt_q[CHANNEL_WIDTH-1:0];
                            chanCnt_d      = chanCnt_q + CNT_ONE;
                        end else begin
                            errOverrun_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    chanCnt_d = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            chanCnt_q      <= '0;
            channelValid_q <= 1'b0;
            channelIndex_q <= '0;
            cycleDone_q    <= 1'b0;
            cycleCount_q   <= '0;
            errShort_q     <= 1'b0;
            errOverrun_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            chanCnt_q      <= chanCnt_d;
            channelValid_q <= channelValid_d;
            channelIndex_q <= channelIndex_d;
            cycleDone_q    <= cycleDone_d;
            cycleCount_q   <= cycleCount_d;
            errShort_q     <= errShort_d;
            errOverrun_q   <= errOverrun_d;
        end
    end

    assign bus.channel_valid = channelValid_q;
    assign bus.channel_index = channelIndex_q;
    assign bus.cycle_done    = cycleDone_q;
    assign bus.cycle_count   = cycleCount_q;
    assign bus.err_short     = errShort_q;
    assign bus.err_overrun   = errOverrun_q;

endmodule
